// File: rtl/jpeg_bit_packer_if.sv
// Stream bundle between the entropy encoder, the bit packer and the byte sink.
// The master side drives codes, flush and out_ready; the slave side is the packer.
interface jpeg_bit_packer_if;
   logic [15:0] in_code;
   logic [3:0]  in_len;
   logic        in_valid;
   logic        in_ready;
   logic        flush;
   logic [7:0]  out_byte;
   logic        out_valid;
   logic        out_ready;
   logic        done;

   modport master (
      output in_code, in_len, in_valid, flush, out_ready,
      input  in_ready, out_byte, out_valid, done
   );

   modport slave (
      input  in_code, in_len, in_valid, flush, out_ready,
      output in_ready, out_byte, out_valid, done
   );
endinterface

// File: rtl/jpeg_bit_packer.sv
// JPEG bit packer: concatenates variable-length codes MSB-first into bytes,
// stuffs 0x00 after every emitted 0xFF, and pads with 1s on end-of-image flush.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_RUN   | normal packing, codes accepted while bit_cnt <= 9
// S_PAD   | one cycle: fill the partial byte with 1-bits
// S_DRAIN | emit remaining bytes (and stuff bytes), no new codes
// S_DONE  | one-cycle done pulse, accumulator cleared, back to S_RUN
module jpeg_bit_packer #(
   parameter bit STUFF_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   jpeg_bit_packer_if.slave bus
);

   typedef enum logic [1:0] {S_RUN, S_PAD, S_DRAIN, S_DONE} state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [23:0] r_acc;
   logic [23:0] w_acc_nxt;
   logic [4:0]  r_bit_cnt;
   logic [4:0]  w_bit_cnt_nxt;
   logic        r_stuff_pend;
   logic        w_stuff_pend_nxt;
   logic [7:0]  r_out_byte;
   logic [7:0]  w_out_byte_nxt;
   logic        r_out_valid;
   logic        w_out_valid_nxt;
   logic        r_live;

   logic        w_in_ready;
   logic        w_accept;
   logic        w_load_ok;
   logic        w_stuff_out;
   logic        w_extract;
   logic        w_pad_en;
   logic        w_done;
   logic [4:0]  w_base;
   logic [3:0]  w_pad_len;
   logic [15:0] w_code_masked;
   logic [5:0]  w_code_sh;
   logic [5:0]  w_pad_sh;
   logic [23:0] w_code_ins;
   logic [23:0] w_pad_ones;
   logic [23:0] w_pad_ins;
   logic [23:0] w_acc_sh;

   // r_live keeps in_ready low while reset is held and until the first clock after release.
   assign w_in_ready  = r_live && (r_state == S_RUN) && (r_bit_cnt <= 5'd9);
   assign w_accept    = bus.in_valid && w_in_ready;
   assign w_load_ok   = !r_out_valid || bus.out_ready;
   assign w_stuff_out = w_load_ok && r_stuff_pend;
   assign w_extract   = w_load_ok && !r_stuff_pend && (r_bit_cnt >= 5'd8);
   assign w_pad_en    = (r_state == S_PAD);

   assign bus.in_ready  = w_in_ready;
   assign bus.out_byte  = r_out_byte;
   assign bus.out_valid = r_out_valid;
   assign bus.done      = w_done;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and done pulse; drain ends once nothing is left in acc or the output register.
   always_comb begin
      w_state_nxt = r_state;
      w_done      = 1'b0;
      case (r_state)
         S_RUN:   if (bus.flush) w_state_nxt = S_PAD;
         S_PAD:   w_state_nxt = S_DRAIN;
         S_DRAIN: if ((r_bit_cnt == 5'd0) && !r_stuff_pend && w_load_ok) w_state_nxt = S_DONE;
         S_DONE: begin
            w_done      = 1'b1;
            w_state_nxt = S_RUN;
         end
         default: w_state_nxt = S_RUN;
      endcase
   end

   // Accumulator datapath: shift out an extracted byte, then append the new code or the pad bits
   // right after whatever valid bits remain.
   always_comb begin
      w_base        = r_bit_cnt - (w_extract ? 5'd8 : 5'd0);
      w_acc_sh      = w_extract ? {r_acc[15:0], 8'd0} : r_acc;
      w_code_masked = bus.in_code & ((16'd1 << bus.in_len) - 16'd1);
      w_code_sh     = 6'd24 - {1'b0, w_base} - {2'b00, bus.in_len};
      w_code_ins    = {8'd0, w_code_masked} << w_code_sh;
      w_pad_len     = (r_bit_cnt[2:0] == 3'd0) ? 4'd0 : (4'd8 - {1'b0, r_bit_cnt[2:0]});
      w_pad_sh      = 6'd24 - {1'b0, w_base} - {2'b00, w_pad_len};
      w_pad_ones    = (24'd1 << w_pad_len) - 24'd1;
      w_pad_ins     = w_pad_ones << w_pad_sh;

      w_acc_nxt     = w_acc_sh;
      w_bit_cnt_nxt = w_base;
      if (w_accept) begin
         w_acc_nxt     = w_acc_nxt | w_code_ins;
         w_bit_cnt_nxt = w_bit_cnt_nxt + {1'b0, bus.in_len};
      end
      if (w_pad_en) begin
         w_acc_nxt     = w_acc_nxt | w_pad_ins;
         w_bit_cnt_nxt = w_bit_cnt_nxt + {1'b0, w_pad_len};
      end
      if (r_state == S_DONE) begin
         w_acc_nxt     = 24'd0;
         w_bit_cnt_nxt = 5'd0;
      end
   end

   // Output register: a pending stuff byte always beats the next data byte.
   always_comb begin
      w_out_byte_nxt   = r_out_byte;
      w_out_valid_nxt  = r_out_valid;
      w_stuff_pend_nxt = r_stuff_pend;
      if (w_stuff_out) begin
         w_out_byte_nxt   = 8'h00;
         w_out_valid_nxt  = 1'b1;
         w_stuff_pend_nxt = 1'b0;
      end else if (w_extract) begin
         w_out_byte_nxt   = r_acc[23:16];
         w_out_valid_nxt  = 1'b1;
         w_stuff_pend_nxt = STUFF_EN && (r_acc[23:16] == 8'hFF);
      end else if (w_load_ok) begin
         w_out_valid_nxt  = 1'b0;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc        <= 24'd0;
         r_bit_cnt    <= 5'd0;
         r_stuff_pend <= 1'b0;
         r_out_byte   <= 8'h00;
         r_out_valid  <= 1'b0;
         r_live       <= 1'b0;
      end else begin
         r_acc        <= w_acc_nxt;
         r_bit_cnt    <= w_bit_cnt_nxt;
         r_stuff_pend <= w_stuff_pend_nxt;
         r_out_byte   <= w_out_byte_nxt;
         r_out_valid  <= w_out_valid_nxt;
         r_live       <= 1'b1;
      end
   end

endmodule

// File: tb/tb_jpeg_bit_packer.sv
// Bench for jpeg_bit_packer: one instance with stuffing, one without, driven in lockstep.
// A bit-level stream model predicts the byte sequence each instance must hand off.
module tb_jpeg_bit_packer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   jpeg_bit_packer_if b1 ();
   jpeg_bit_packer_if b0 ();

   jpeg_bit_packer #(.STUFF_EN(1'b1)) dut_s1 (.clk(clk), .rst_n(rst_n), .bus(b1));
   jpeg_bit_packer #(.STUFF_EN(1'b0)) dut_s0 (.clk(clk), .rst_n(rst_n), .bus(b0));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Stream model: pending bits of the current byte, expected handoff bytes per instance.
   logic [7:0] mbits [2];
   int         mcnt [2];
   bit         flushing [2];
   int         done_cnt [2];
   bit         stall_q [2];
   logic [7:0] stall_b [2];
   logic [7:0] exp1 [$];
   logic [7:0] exp0 [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic int qsize(input int i);
      return (i == 1) ? exp1.size() : exp0.size();
   endfunction

   function automatic logic [7:0] qpop(input int i);
      if (i == 1) return exp1.pop_front();
      return exp0.pop_front();
   endfunction

   task automatic emit(input int i, input logic [7:0] b);
      if (i == 1) begin
         exp1.push_back(b);
         if (b == 8'hFF) exp1.push_back(8'h00);
      end else begin
         exp0.push_back(b);
      end
   endtask

   task automatic push_bits(input int i, input logic [15:0] v, input int n);
      for (int k = n - 1; k >= 0; k--) begin
         mbits[i] = {mbits[i][6:0], v[k]};
         mcnt[i]++;
         if (mcnt[i] == 8) begin
            emit(i, mbits[i]);
            mcnt[i] = 0;
         end
      end
   endtask

   task automatic model_clear();
      exp1.delete();
      exp0.delete();
      for (int i = 0; i < 2; i++) begin
         mbits[i] = 8'h00;
         mcnt[i] = 0;
         flushing[i] = 1'b0;
         stall_q[i] = 1'b0;
      end
   endtask

   task automatic mon(input int i, input logic [15:0] c, input logic [3:0] l, input logic iv,
                      input logic ir, input logic fl, input logic [7:0] ob, input logic ov,
                      input logic ordy, input logic dn);
      string sfx;
      sfx = (i == 1) ? "_s1" : "_s0";
      if (flushing[i]) check({"in_ready_low_in_flush", sfx}, 32'(ir), 32'd0);
      if (stall_q[i]) begin
         check({"held_valid", sfx}, 32'(ov), 32'd1);
         check({"held_byte", sfx}, 32'(ob), 32'(stall_b[i]));
      end
      if (iv && ir) push_bits(i, c, int'(l));
      if (fl && !flushing[i]) begin
         if (mcnt[i] != 0) push_bits(i, 16'hFFFF, 8 - mcnt[i]);
         flushing[i] = 1'b1;
      end
      if (ov && ordy) begin
         check({"byte_was_expected", sfx}, 32'(qsize(i) != 0), 32'd1);
         if (qsize(i) != 0) check({"byte", sfx}, 32'(ob), 32'(qpop(i)));
      end
      stall_q[i] = ov && !ordy;
      stall_b[i] = ob;
      if (dn) begin
         check({"done_after_flush", sfx}, 32'(flushing[i]), 32'd1);
         check({"done_all_sent", sfx}, 32'(qsize(i)), 32'd0);
         flushing[i] = 1'b0;
         done_cnt[i]++;
      end
   endtask

   // Handshakes are sampled mid-cycle; inputs change just after the rising edge.
   always @(negedge clk) begin
      if (rst_n) begin
         mon(1, b1.in_code, b1.in_len, b1.in_valid, b1.in_ready, b1.flush,
             b1.out_byte, b1.out_valid, b1.out_ready, b1.done);
         mon(0, b0.in_code, b0.in_len, b0.in_valid, b0.in_ready, b0.flush,
             b0.out_byte, b0.out_valid, b0.out_ready, b0.done);
      end else begin
         stall_q[0] = 1'b0;
         stall_q[1] = 1'b0;
      end
   end

   task automatic drv(input logic [15:0] c, input logic [3:0] l, input logic v,
                      input logic f, input logic r);
      b1.in_code = c;  b1.in_len = l;  b1.in_valid = v;  b1.flush = f;  b1.out_ready = r;
      b0.in_code = c;  b0.in_len = l;  b0.in_valid = v;  b0.flush = f;  b0.out_ready = r;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      drv(16'h0, 4'd0, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic wait_done();
      int d1;
      int d0;
      int n;
      d1 = done_cnt[1];
      d0 = done_cnt[0];
      n = 0;
      while ((done_cnt[1] == d1 || done_cnt[0] == d0) && n < 400) begin
         tick();
         n++;
      end
      check("done_within_bound", 32'(done_cnt[1] != d1 && done_cnt[0] != d0), 32'd1);
   endtask

   initial begin
      done_cnt[0] = 0;
      done_cnt[1] = 0;
      model_clear();
      drv(16'h0, 4'd0, 1'b0, 1'b0, 1'b1);

      // Reset state.
      #2;
      check("rst_in_ready", 32'(b1.in_ready), 32'd0);
      check("rst_out_valid", 32'(b1.out_valid), 32'd0);
      check("rst_done", 32'(b1.done), 32'd0);
      check("rst_out_byte", 32'(b1.out_byte), 32'h00);
      tick(); tick(); tick();
      rst_n = 1'b1;
      tick();
      check("post_rst_in_ready", 32'(b1.in_ready), 32'd1);

      // 101 + 11111 -> 0xBF one cycle after the completing accept.
      drv(16'h0005, 4'd3, 1'b1, 1'b0, 1'b1); tick();
      drv(16'h001F, 4'd5, 1'b1, 1'b0, 1'b1); tick();
      drv(16'h0000, 4'd0, 1'b0, 1'b0, 1'b1); tick();
      check("bf_valid", 32'(b1.out_valid), 32'd1);
      check("bf_byte", 32'(b1.out_byte), 32'hBF);
      idle(3);

      // 0xFF: stuffed instance gives FF 00, the other only FF.
      drv(16'h00FF, 4'd8, 1'b1, 1'b0, 1'b1); tick();
      drv(16'h0000, 4'd0, 1'b0, 1'b0, 1'b1); tick();
      check("ff_byte_s1", 32'(b1.out_byte), 32'hFF);
      check("ff_byte_s0", 32'(b0.out_byte), 32'hFF);
      tick();
      check("stuff_valid_s1", 32'(b1.out_valid), 32'd1);
      check("stuff_byte_s1", 32'(b1.out_byte), 32'h00);
      check("nostuff_valid_s0", 32'(b0.out_valid), 32'd0);
      idle(3);

      // 010 then flush -> 0x5F, done one cycle after its handshake.
      drv(16'h0002, 4'd3, 1'b1, 1'b0, 1'b1); tick();
      drv(16'h0000, 4'd0, 1'b0, 1'b1, 1'b1); tick();
      drv(16'h0000, 4'd0, 1'b0, 1'b0, 1'b1); tick(); tick();
      check("pad_valid", 32'(b1.out_valid), 32'd1);
      check("pad_byte", 32'(b1.out_byte), 32'h5F);
      check("pad_done_early", 32'(b1.done), 32'd0);
      tick();
      check("pad_done", 32'(b1.done), 32'd1);
      check("pad_no_more", 32'(b1.out_valid), 32'd0);
      tick();
      check("pad_done_one_cycle", 32'(b1.done), 32'd0);
      idle(2);

      // Zero-length code, then an empty flush: done three cycles after the flush cycle.
      drv(16'h1234, 4'd0, 1'b1, 1'b0, 1'b1); tick();
      check("len0_in_ready", 32'(b1.in_ready), 32'd1);
      idle(2);
      check("len0_no_out", 32'(b1.out_valid), 32'd0);
      drv(16'h0000, 4'd0, 1'b0, 1'b1, 1'b1); tick();
      drv(16'h0000, 4'd0, 1'b0, 1'b0, 1'b1); tick();
      check("empty_flush_done_early", 32'(b1.done), 32'd0);
      tick();
      check("empty_flush_done", 32'(b0.done), 32'd1);
      idle(2);

      // Back-pressure with 15-bit 0x7FFF codes, then release and flush.
      drv(16'h7FFF, 4'd15, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 6; k++) tick();
      check("stall_in_ready", 32'(b1.in_ready), 32'd0);
      check("stall_valid", 32'(b1.out_valid), 32'd1);
      check("stall_byte", 32'(b1.out_byte), 32'hFF);
      drv(16'h0000, 4'd0, 1'b0, 1'b1, 1'b1); tick();
      check("release_stuff_s1", 32'(b1.out_byte), 32'h00);
      check("release_next_s0", 32'(b0.out_byte), 32'hFF);
      idle(0);
      wait_done();
      idle(2);

      // Randomized rounds, each closed by a flush.
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 150; k++) begin
            drv(($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom),
                4'($urandom_range(0, 15)),
                $urandom_range(0, 9) < 7, 1'b0,
                $urandom_range(0, 9) < 8);
            tick();
         end
         drv(16'h0000, 4'd0, 1'b0, 1'b1, 1'b1); tick();
         idle(0);
         wait_done();
         check("rand_drained_s1", 32'(exp1.size()), 32'd0);
         check("rand_drained_s0", 32'(exp0.size()), 32'd0);
         idle(2);
      end

      // Reset in the middle of a drain discards everything.
      drv(16'h1234, 4'd15, 1'b1, 1'b0, 1'b0); tick(); tick(); tick();
      drv(16'h0000, 4'd0, 1'b0, 1'b1, 1'b0); tick();
      drv(16'h0000, 4'd0, 1'b0, 1'b0, 1'b0); tick(); tick();
      rst_n = 1'b0;
      #2;
      check("midrst_out_valid", 32'(b1.out_valid), 32'd0);
      check("midrst_done", 32'(b1.done), 32'd0);
      check("midrst_in_ready", 32'(b1.in_ready), 32'd0);
      model_clear();
      drv(16'h0000, 4'd0, 1'b0, 1'b0, 1'b1);
      tick(); tick();
      rst_n = 1'b1;
      tick();
      check("after_rst_out_valid", 32'(b1.out_valid), 32'd0);
      check("after_rst_done", 32'(b1.done), 32'd0);
      check("after_rst_in_ready", 32'(b1.in_ready), 32'd1);
      drv(16'h00AB, 4'd8, 1'b1, 1'b0, 1'b1); tick();
      drv(16'h0000, 4'd0, 1'b0, 1'b0, 1'b1); tick();
      check("after_rst_valid", 32'(b1.out_valid), 32'd1);
      check("after_rst_byte", 32'(b1.out_byte), 32'hAB);
      idle(3);
      check("final_empty_s1", 32'(exp1.size()), 32'd0);
      check("final_empty_s0", 32'(exp0.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
